i_encoder_n_rr: RTL
===================

I_ENCODER_N_RR -- requirements
Module: i_encoder_n_rr

Interface
REQ-001 Parameter N, default 4: number of request inputs; legal values are powers of two from 2 to 32.
REQ-002 Parameter W, default $clog2(N): index width; W SHALL NOT be overridden independently of N.
REQ-003 Parameter MODE, default "PRIORITY": arbitration mode; legal values are "PRIORITY" and "ROUND_ROBIN".
REQ-004 Parameter ACTIVE_LOW, default 1: when 1, a request is a 0 on a[i]; when 0, a request is a 1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 en  input  1  sample enable; a[] is considered only when en=1.
REQ-008 a  input  N  request vector, polarity per ACTIVE_LOW.
REQ-009 ready  input  1  downstream accepts the current result when ready=1 and valid=1.
REQ-010 b  output  W  registered index of the granted request.
REQ-011 valid  output  1  b holds an unconsumed grant.
REQ-012 none  output  1  registered flag: last sample taken had no active request.

Function
REQ-013 Normalised request vector r = ACTIVE_LOW ? ~a : a; all arbitration SHALL use r.
REQ-014 Load condition: load = en & (~valid | ready).
REQ-015 On load with r != 0: b <= selected index; valid <= 1; none <= 0.
REQ-016 On load with r == 0: valid <= 0; none <= 1; b holds its value.
REQ-017 No load and valid & ready: valid <= 0; b and none hold.
REQ-018 No load and (~valid | ~ready): b, valid and none hold, so b stays stable while valid=1 and ready=0.
REQ-019 Latency: one clock from a sampled a[] to the corresponding b/valid.
REQ-020 A result accepted with ready=1 SHALL be replaced by the new sample in the same edge, giving back-to-back grants at full rate.
REQ-021 MODE "PRIORITY": the selected index is the highest set bit of r, e.g. index 3 beats index 0.
REQ-022 MODE "ROUND_ROBIN": a pointer p (W bits) is kept; the selected index is the first set bit of r at or after p, searching upward with modulo-N wrap.
REQ-023 ROUND_ROBIN pointer update: on a load with r != 0, p <= (granted index + 1) mod N; otherwise p holds.
REQ-024 Wrap-around: a grant at index N-1 SHALL set p to 0.
REQ-025 Multiple simultaneous requests SHALL produce exactly one grant per load; there is no output for the other requests.
REQ-026 In "PRIORITY" mode p SHALL NOT exist or SHALL have no effect.

Reset
REQ-027 While rst_n=0 at a rising edge: b <= 0, valid <= 0, none <= 1, p <= 0.
REQ-028 Reset SHALL override load in the same cycle; a grant pending at reset is discarded.
REQ-029 The first load is possible on the first edge after rst_n returns to 1.

Structure
REQ-030 A shared package i_encoder_pkg SHALL hold the MODE string constants and the legal-N check.
REQ-031 The package SHALL hold a function mapping a one-hot or multi-hot vector plus start pointer to an index.
REQ-032 One sub-module, i_prio_core, SHALL be combinational: inputs r and p, outputs the index and an any-request flag.
REQ-033 i_encoder_n_rr SHALL contain the handshake registers and pointer only.
REQ-034 An illegal N or MODE SHALL stop elaboration with an error.

Verification (N=4, ACTIVE_LOW=1 unless stated)
REQ-035 Walking zero, PRIORITY mode: a=1110, 1101, 1011, 0111 with en=1 and ready=1 -> b=0, 1, 2, 3 one cycle later, valid=1 each cycle.
REQ-036 PRIORITY mode with a=0000 -> b=3; then a=1111 -> valid=0 and none=1.
REQ-037 ROUND_ROBIN mode with a=0000 held and ready=1 -> b=0, 1, 2, 3, 0 on consecutive cycles (wrap).
REQ-038 Backpressure: load a=1011 (b=2), then ready=0 for 3 cycles while a changes -> b=2 and valid=1 stay stable; ready=1 -> the next sample loads.
REQ-039 Reset mid-operation: ROUND_ROBIN with p=2, assert rst_n=0 for one edge -> valid=0, none=1, b=0; then a=0000 -> b=0.
REQ-040 ACTIVE_LOW=0 and N=8, PRIORITY mode, a=8'h41 -> b=6.

Source files
------------

// File: rtl/i_encoder_pkg.sv
// rtl/i_encoder_pkg.sv - shared constants and index selection for the request encoder
// Purpose: MODE string constants, legal-N check, and the index-select function
//          used by i_prio_core. No ports (package).
package i_encoder_pkg;

  localparam string MODE_PRIORITY = "PRIORITY";
  localparam string MODE_RR       = "ROUND_ROBIN";
  localparam int    MAX_N         = 32;

  // N must be a power of two in [2, 32].
  function automatic bit n_legal(input int n);
    return (n >= 2) && (n <= MAX_N) && ((n & (n - 1)) == 0);
  endfunction

  // Maps a (multi-hot) request vector to one index.
  // rr=0: highest set bit wins.
  // rr=1: first set bit at or after start, searching upward modulo n. The loop
  //       walks distances from far to near so the nearest hit is written last.
  function automatic int sel_index(input logic [MAX_N-1:0] r,
                                   input logic [4:0]       start,
                                   input int               n,
                                   input bit               rr);
    int idx;
    int k;
    idx = 0;
    k   = 0;
    if (rr) begin
      for (int i = MAX_N - 1; i >= 0; i--) begin
        if (i < n) begin
          k = (int'(start) + i) % n;
          if (r[k[4:0]]) idx = k;
        end
      end
    end else begin
      for (int i = 0; i < MAX_N; i++) begin
        if ((i < n) && r[i[4:0]]) idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/i_prio_core.sv
// rtl/i_prio_core.sv - combinational request-to-index selector
// Purpose: picks one index out of the normalised request vector.
// Ports:
//   r_i    [N-1:0] normalised requests (1 = active)
//   p_i    [W-1:0] round-robin start pointer (ignored when RR=0)
//   idx_o  [W-1:0] selected index (0 when no request)
//   any_o          at least one request active
module i_prio_core
  import i_encoder_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = $clog2(N),
  parameter bit RR = 1'b0
) (
  input  logic [N-1:0] r_i,
  input  logic [W-1:0] p_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  assign idx_o = W'(sel_index(32'(r_i), 5'(p_i), N, RR));
  assign any_o = |r_i;

endmodule

// File: rtl/i_encoder_n_rr.sv
// rtl/i_encoder_n_rr.sv - registered priority / round-robin request encoder with handshake
// Purpose: samples a[] when en=1 and the output slot is free or being consumed,
//          and presents the granted index on b with a valid/ready handshake.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   en     sample enable
//   a      [N-1:0] request vector (0 = request when ACTIVE_LOW=1)
//   ready  downstream accepts b when valid=1
//   b      [W-1:0] registered granted index
//   valid  b holds an unconsumed grant
//   none   last sample taken had no active request
module i_encoder_n_rr
  import i_encoder_pkg::*;
#(
  parameter int    N          = 4,
  parameter int    W          = $clog2(N),
  parameter string MODE       = "PRIORITY",
  parameter bit    ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] a,
  input  logic         ready,
  output logic [W-1:0] b,
  output logic         valid,
  output logic         none
);

  localparam bit IS_RR = (MODE == MODE_RR);

  if (!n_legal(N)) begin : g_bad_n
    $error("i_encoder_n_rr: N must be a power of two from 2 to 32");
  end
  if (!((MODE == MODE_PRIORITY) || (MODE == MODE_RR))) begin : g_bad_mode
    $error("i_encoder_n_rr: MODE must be PRIORITY or ROUND_ROBIN");
  end
  if (W != $clog2(N)) begin : g_bad_w
    $error("i_encoder_n_rr: W must equal clog2(N)");
  end

  logic [N-1:0] r;
  logic [W-1:0] idx;
  logic         any;
  logic         load;

  logic [W-1:0] b_q, b_d;
  logic         valid_q, valid_d;
  logic         none_q, none_d;
  logic [W-1:0] p_q, p_d;

  assign r    = ACTIVE_LOW ? ~a : a;
  assign load = en & (~valid_q | ready);

  i_prio_core #(
    .N  (N),
    .W  (W),
    .RR (IS_RR)
  ) u_core (
    .r_i   (r),
    .p_i   (p_q),
    .idx_o (idx),
    .any_o (any)
  );

  always_comb begin
    b_d     = b_q;
    valid_d = valid_q;
    none_d  = none_q;
    p_d     = p_q;
    if (load) begin
      if (any) begin
        b_d     = idx;
        valid_d = 1'b1;
        none_d  = 1'b0;
        // N is a power of two, so W-bit overflow is exactly the modulo-N wrap.
        // In PRIORITY mode the pointer stays at 0 and the core ignores it.
        if (IS_RR) p_d = idx + W'(1);
      end else begin
        valid_d = 1'b0;
        none_d  = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_q     <= '0;
      valid_q <= 1'b0;
      none_q  <= 1'b1;
      p_q     <= '0;
    end else begin
      b_q     <= b_d;
      valid_q <= valid_d;
      none_q  <= none_d;
      p_q     <= p_d;
    end
  end

  assign b     = b_q;
  assign valid = valid_q;
  assign none  = none_q;

endmodule
